// File: rtl/a2d_spi_resp.sv
// SPI slave stand-in for the 8-channel 12-bit A2D: decodes the channel command in
// each 16-bit frame and returns that channel's conversion value in the next frame.
module a2d_spi_resp #(
  parameter bit          RESP_INV = 1'b1,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [95:0] ch_data,
  output logic [2:0]  chnnl,
  output logic [15:0] cmd,
  output logic        cmd_vld,
  output logic        frm_err
);

  localparam int unsigned CH_W  = 12;
  localparam int unsigned N_CH  = 8;
  localparam int unsigned FRM_W = 16;
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRM_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_n;
  logic [SYNC_STG-1:0] ss_pipe, sclk_pipe, mosi_pipe;
  logic               ss_hist, sclk_hist;
  logic               ss_fall, ss_rise, sclk_fall, sclk_rise, mosi_sync;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [FRM_W-1:0]   rx_shft, rx_shft_n, tx_shft, tx_shft_n, tx_load;
  logic [FRM_W-1:0]   cmd_n;
  logic [2:0]         chnnl_n;
  logic               miso_n, cmd_vld_n, frm_err_n;
  logic [CH_W-1:0]    ch_sel;

  // Input synchronizers plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_pipe   <= '1;
      sclk_pipe <= '1;
      mosi_pipe <= '0;
      ss_hist   <= 1'b1;
      sclk_hist <= 1'b1;
    end else begin
      ss_pipe   <= {ss_pipe[SYNC_STG-2:0], SS_n};
      sclk_pipe <= {sclk_pipe[SYNC_STG-2:0], SCLK};
      mosi_pipe <= {mosi_pipe[SYNC_STG-2:0], MOSI};
      ss_hist   <= ss_pipe[SYNC_STG-1];
      sclk_hist <= sclk_pipe[SYNC_STG-1];
    end
  end

  assign ss_fall   = ~ss_pipe[SYNC_STG-1] & ss_hist;
  assign ss_rise   = ss_pipe[SYNC_STG-1] & ~ss_hist;
  assign sclk_fall = ~sclk_pipe[SYNC_STG-1] & sclk_hist;
  assign sclk_rise = sclk_pipe[SYNC_STG-1] & ~sclk_hist;
  assign mosi_sync = mosi_pipe[SYNC_STG-1];

  // Channel value selected by the last decoded command
  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (chnnl == 3'(i)) ch_sel = ch_data[CH_W*i +: CH_W];
    end
  end

  assign tx_load = {4'b0000, RESP_INV ? ~ch_sel : ch_sel};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rx_shft <= '0;
      tx_shft <= '0;
      MISO    <= 1'b0;
      chnnl   <= '0;
      cmd     <= '0;
      cmd_vld <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      rx_shft <= rx_shft_n;
      tx_shft <= tx_shft_n;
      MISO    <= miso_n;
      chnnl   <= chnnl_n;
      cmd     <= cmd_n;
      cmd_vld <= cmd_vld_n;
      frm_err <= frm_err_n;
    end
  end

  // Frame sequencing; a fresh ss_fall always restarts the frame
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    rx_shft_n = rx_shft;
    tx_shft_n = tx_shft;
    miso_n    = MISO;
    chnnl_n   = chnnl;
    cmd_n     = cmd;
    cmd_vld_n = 1'b0;
    frm_err_n = 1'b0;

    if (ss_fall) begin
      state_n   = SHIFT;
      tx_shft_n = tx_load;
      miso_n    = tx_load[FRM_W-1];
      bit_cnt_n = '0;
      rx_shft_n = '0;
    end else if (state == SHIFT) begin
      if (ss_rise) begin
        state_n = IDLE;
        if (bit_cnt == FULL_CNT) begin
          cmd_n     = rx_shft;
          chnnl_n   = rx_shft[13:11];
          cmd_vld_n = 1'b1;
        end else begin
          frm_err_n = 1'b1;
        end
      end else begin
        if (sclk_rise) begin
          rx_shft_n = {rx_shft[FRM_W-2:0], mosi_sync};
          bit_cnt_n = (bit_cnt == FULL_CNT) ? bit_cnt : bit_cnt + CNT_W'(1);
        end
        // The fall ahead of the first rise carries no new data
        if (sclk_fall && (bit_cnt != '0)) begin
          tx_shft_n = {tx_shft[FRM_W-2:0], 1'b0};
          miso_n    = tx_shft[FRM_W-2];
        end
      end
    end
  end

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: inverted (SYNC_STG=2) and true-polarity (SYNC_STG=3)
// instances driven by one SPI master and checked against a frame-level model.
module tb_a2d_spi_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic [95:0] ch_data = '0;
  logic        miso_inv, miso_tru;
  logic [2:0]  chnnl_inv, chnnl_tru;
  logic [15:0] cmd_inv, cmd_tru;
  logic        vld_inv, vld_tru, err_inv, err_tru;

  int n_cmp = 0;
  int n_bad = 0;
  int vld_cnt_inv = 0, vld_cnt_tru = 0, err_cnt_inv = 0, err_cnt_tru = 0;

  logic [11:0] chv [8];
  logic [2:0]  exp_ch = '0;
  logic [15:0] exp_cmd = '0;
  int          exp_vld = 0;
  int          exp_err = 0;

  a2d_spi_resp #(.RESP_INV(1'b1), .SYNC_STG(2)) u_inv (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso_inv),
    .ch_data(ch_data), .chnnl(chnnl_inv), .cmd(cmd_inv), .cmd_vld(vld_inv), .frm_err(err_inv)
  );

  a2d_spi_resp #(.RESP_INV(1'b0), .SYNC_STG(3)) u_tru (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso_tru),
    .ch_data(ch_data), .chnnl(chnnl_tru), .cmd(cmd_tru), .cmd_vld(vld_tru), .frm_err(err_tru)
  );

  always #5 clk = ~clk;

  // Count high cycles of each pulse output
  always @(posedge clk) begin
    if (vld_inv) vld_cnt_inv++;
    if (vld_tru) vld_cnt_tru++;
    if (err_inv) err_cnt_inv++;
    if (err_tru) err_cnt_tru++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_ch();
    for (int i = 0; i < 8; i++) ch_data[12*i +: 12] = chv[i];
  endtask

  task automatic rand_ch();
    for (int i = 0; i < 8; i++) chv[i] = 12'($urandom);
    apply_ch();
  endtask

  task automatic check_state(input string tag);
    check({tag, ".cmd_inv"}, 32'(cmd_inv), 32'(exp_cmd));
    check({tag, ".cmd_tru"}, 32'(cmd_tru), 32'(exp_cmd));
    check({tag, ".ch_inv"}, 32'(chnnl_inv), 32'(exp_ch));
    check({tag, ".ch_tru"}, 32'(chnnl_tru), 32'(exp_ch));
    check({tag, ".vld_inv"}, 32'(vld_cnt_inv), 32'(exp_vld));
    check({tag, ".vld_tru"}, 32'(vld_cnt_tru), 32'(exp_vld));
    check({tag, ".err_inv"}, 32'(err_cnt_inv), 32'(exp_err));
    check({tag, ".err_tru"}, 32'(err_cnt_tru), 32'(exp_err));
  endtask

  // One master frame of nrise SCLK periods; the response expected is the channel
  // chosen by the previous complete command, captured when SS_n falls.
  task automatic run_frame(input string tag, input logic [15:0] word, input int nrise,
                           input bit mid_change);
    logic [15:0] rsp_inv, rsp_tru, rd_inv, rd_tru, rx;
    logic        b;
    int          sh;
    rsp_tru = {4'b0000, chv[exp_ch]};
    rsp_inv = {4'b0000, ~chv[exp_ch]};
    rd_inv = '0;
    rd_tru = '0;
    rx = '0;
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    if (mid_change) rand_ch();
    for (int i = 0; i < nrise; i++) begin
      b = (i < 16) ? word[15-i] : 1'($urandom);
      SCLK = 1'b0;
      MOSI = b;
      repeat (16) @(negedge clk);
      if (i < 16) begin
        rd_inv[15-i] = miso_inv;
        rd_tru[15-i] = miso_tru;
      end else begin
        check({tag, ".extra_inv"}, 32'(miso_inv), 32'd0);
        check({tag, ".extra_tru"}, 32'(miso_tru), 32'd0);
      end
      SCLK = 1'b1;
      rx = {rx[14:0], b};
      repeat (16) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    SS_n = 1'b1;
    repeat (12) @(negedge clk);
    sh = (nrise >= 16) ? 0 : 16 - nrise;
    check({tag, ".rd_inv"}, 32'(rd_inv >> sh), 32'(rsp_inv >> sh));
    check({tag, ".rd_tru"}, 32'(rd_tru >> sh), 32'(rsp_tru >> sh));
    if (nrise >= 16) begin
      exp_cmd = rx;
      exp_ch  = rx[13:11];
      exp_vld++;
    end else begin
      exp_err++;
    end
    check_state(tag);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) chv[i] = 12'($urandom);
    chv[3] = 12'hA5C;
    chv[7] = 12'h123;
    chv[0] = 12'hFFF;
    chv[5] = 12'h800;
    apply_ch();
    repeat (4) @(negedge clk);
    check("rst.miso_inv", 32'(miso_inv), 32'd0);
    check("rst.miso_tru", 32'(miso_tru), 32'd0);
    check_state("rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run_frame("f_ch3", 16'h1800, 16, 1'b0);
    run_frame("f_ch7", 16'h3800, 16, 1'b0);
    run_frame("f_ch0", 16'h0000, 16, 1'b0);
    run_frame("f_ch5", 16'h2800, 16, 1'b0);
    run_frame("short9", 16'($urandom), 9, 1'b0);
    run_frame("long17", 16'h2800, 17, 1'b0);

    // Reset pulse in the middle of a frame, with SCLK high after bit 8
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      SCLK = 1'b0;
      MOSI = 1'($urandom);
      repeat (16) @(negedge clk);
      SCLK = 1'b1;
      repeat (8) @(negedge clk);
      if (i < 7) repeat (8) @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ch = '0;
    exp_cmd = '0;
    check("midrst.miso_inv", 32'(miso_inv), 32'd0);
    check("midrst.miso_tru", 32'(miso_tru), 32'd0);
    check_state("midrst");
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      SCLK = 1'b0;
      MOSI = 1'($urandom);
      repeat (16) @(negedge clk);
      SCLK = 1'b1;
      repeat (16) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    SS_n = 1'b1;
    repeat (12) @(negedge clk);
    exp_err++;
    check_state("midrst_end");
    run_frame("post_rst", 16'($urandom), 16, 1'b0);

    for (int k = 0; k < 24; k++) begin
      int r;
      int n;
      r = int'($urandom_range(0, 9));
      n = (r == 0) ? int'($urandom_range(1, 15)) : ((r == 1) ? 17 : 16);
      if ($urandom_range(0, 1) == 0) rand_ch();
      run_frame("rand", 16'($urandom), n, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
